// File: rtl/cache_bus_pkg.sv
// Shared types and helpers for the cache-side to AXI4 bridge.
package cache_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned TYPE_W = 3;

  localparam logic [TYPE_W-1:0] TYPE_BYTE = 3'b000;
  localparam logic [TYPE_W-1:0] TYPE_HALF = 3'b001;
  localparam logic [TYPE_W-1:0] TYPE_WORD = 3'b010;
  localparam logic [TYPE_W-1:0] TYPE_LINE = 3'b100;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW_W,
    ST_B
  } bridge_state_e;

  // Latched cache request (reads leave wstrb/data unused)
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TYPE_W-1:0] req_type;
    logic [STRB_W-1:0] wstrb;
    logic [LINE_W-1:0] data;
  } cache_req_t;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
  } axlen_size_t;

  // Burst length/size for a request type; lines are 4 x 32-bit INCR beats
  function automatic axlen_size_t type_to_axlen_size(input logic [TYPE_W-1:0] req_type);
    axlen_size_t r;
    if (req_type == TYPE_LINE) begin
      r.len  = 8'd3;
      r.size = 3'b010;
    end else begin
      r.len  = 8'd0;
      r.size = {1'b0, req_type[1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_axi_bridge_if.sv
// AXI4 master-side bus bundle between the bridge and the interconnect.
interface cache_axi_bridge_if #(
  parameter int unsigned ID_W = 4
);
  import cache_bus_pkg::*;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/cache_wbeat_serializer.sv
// Splits a latched 128-bit line into 32-bit W beats; single-beat for non-line writes.
module cache_wbeat_serializer
  import cache_bus_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic              line,
  input  logic [LINE_W-1:0] line_data,
  input  logic [STRB_W-1:0] strb,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast
);

  logic [1:0] beat_q;

  // Beat counter: cleared per write, steps on each accepted W beat, wraps 3 -> 0
  always_ff @(posedge clock) begin
    if (reset) begin
      beat_q <= '0;
    end else if (clear) begin
      beat_q <= '0;
    end else if (advance) begin
      beat_q <= beat_q + 2'd1;
    end
  end

  // Beat select: line writes walk words 0..3 with full strobes
  always_comb begin
    wdata = line_data[DATA_W-1:0];
    wstrb = strb;
    wlast = 1'b1;
    if (line) begin
      wdata = line_data[{beat_q, 5'd0} +: DATA_W];
      wstrb = '1;
      wlast = (beat_q == 2'd3);
    end
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache request -> AXI4 master bridge, one transaction in flight at a time.
// Optional CACHE_BRIDGE_BUS_ERR_EN adds bus_err / bus_err_addr error reporting.
module cache_axi_bridge
  import cache_bus_pkg::*;
#(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned RD_ID = 0,
  parameter int unsigned WR_ID = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [TYPE_W-1:0] rd_type,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rdy,
  output logic              ret_valid,
  output logic              ret_last,
  output logic [DATA_W-1:0] ret_data,
  input  logic              wr_req,
  input  logic [TYPE_W-1:0] wr_type,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [STRB_W-1:0] wr_wstrb,
  input  logic [LINE_W-1:0] wr_data,
  output logic              wr_rdy,
`ifdef CACHE_BRIDGE_BUS_ERR_EN
  output logic              bus_err,
  output logic [ADDR_W-1:0] bus_err_addr,
`endif
  cache_axi_bridge_if.master axi
);

  bridge_state_e state_q, state_d;
  cache_req_t    req_q;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic          rd_acc, wr_acc, is_line;
  logic          ar_valid, r_ready, aw_valid, w_valid, b_ready;
  axlen_size_t   ax_ls;
  logic [ADDR_W-1:0] ax_addr;
  logic [DATA_W-1:0] ser_wdata;
  logic [STRB_W-1:0] ser_wstrb;
  logic              ser_wlast;
  logic              unused_resp;

  assign wr_rdy = (state_q == ST_IDLE);
  assign rd_rdy = (state_q == ST_IDLE) && !wr_req;
  assign wr_acc = wr_req && wr_rdy;
  assign rd_acc = rd_req && rd_rdy;

  assign is_line = (req_q.req_type == TYPE_LINE);
  assign ax_ls   = type_to_axlen_size(req_q.req_type);
  assign ax_addr = is_line ? {req_q.addr[ADDR_W-1:4], 4'b0} : req_q.addr;

  assign axi.arid    = ID_W'(RD_ID);
  assign axi.araddr  = ax_addr;
  assign axi.arlen   = ax_ls.len;
  assign axi.arsize  = ax_ls.size;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arvalid = ar_valid;
  assign axi.rready  = r_ready;
  assign axi.awid    = ID_W'(WR_ID);
  assign axi.awaddr  = ax_addr;
  assign axi.awlen   = ax_ls.len;
  assign axi.awsize  = ax_ls.size;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awvalid = aw_valid;
  assign axi.wdata   = ser_wdata;
  assign axi.wstrb   = ser_wstrb;
  assign axi.wlast   = ser_wlast;
  assign axi.wvalid  = w_valid;
  assign axi.bready  = b_ready;

  assign ret_valid = (state_q == ST_R) && axi.rvalid;
  assign ret_last  = ret_valid && axi.rlast;
  assign ret_data  = (state_q == ST_R) ? axi.rdata : '0;

  assign unused_resp = ^{axi.rid, axi.bid, axi.rresp, axi.bresp};

  // State and handshake-tracking registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next state and AXI channel valids/readies
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (wr_acc) begin
          state_d = ST_AW_W;
        end else if (rd_acc) begin
          state_d = ST_AR;
        end
      end
      ST_AR: begin
        ar_valid = 1'b1;
        if (axi.arready) state_d = ST_R;
      end
      ST_R: begin
        r_ready = 1'b1;
        if (axi.rvalid && axi.rlast) state_d = ST_IDLE;
      end
      ST_AW_W: begin
        aw_valid = !aw_done_q;
        w_valid  = !w_done_q;
        if (aw_valid && axi.awready) aw_done_d = 1'b1;
        if (w_valid && axi.wready && ser_wlast) w_done_d = 1'b1;
        if (aw_done_d && w_done_d) state_d = ST_B;
      end
      ST_B: begin
        b_ready = 1'b1;
        if (axi.bvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch on acceptance; write takes priority
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q <= '0;
    end else if (wr_acc) begin
      req_q <= '{addr: wr_addr, req_type: wr_type, wstrb: wr_wstrb, data: wr_data};
    end else if (rd_acc) begin
      req_q <= '{addr: rd_addr, req_type: rd_type, wstrb: '0, data: '0};
    end
  end

  cache_wbeat_serializer u_wbeat (
    .clock     (clock),
    .reset     (reset),
    .clear     (wr_acc),
    .advance   (w_valid && axi.wready),
    .line      (is_line),
    .line_data (req_q.data),
    .strb      (req_q.wstrb),
    .wdata     (ser_wdata),
    .wstrb     (ser_wstrb),
    .wlast     (ser_wlast)
  );

`ifdef CACHE_BRIDGE_BUS_ERR_EN
  logic err_hit;
  assign err_hit = ((state_q == ST_R) && axi.rvalid && axi.rresp[1]) ||
                   ((state_q == ST_B) && axi.bvalid && axi.bresp[1]);

  // One-cycle error pulse; address held until the next error
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_err      <= 1'b0;
      bus_err_addr <= '0;
    end else begin
      bus_err <= err_hit;
      if (err_hit) bus_err_addr <= req_q.addr;
    end
  end
`endif

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed self-checking bench for cache_axi_bridge.
`timescale 1ns/1ps
module tb_cache_axi_bridge;
  import cache_bus_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
`ifdef CACHE_BRIDGE_BUS_ERR_EN
  logic         bus_err;
  logic [31:0]  bus_err_addr;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] lrd [4];
  logic [31:0] lwr [4];

  cache_axi_bridge_if #(.ID_W(4)) axi ();

  cache_axi_bridge #(.ID_W(4), .RD_ID(0), .WR_ID(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .rd_req       (rd_req),
    .rd_type      (rd_type),
    .rd_addr      (rd_addr),
    .rd_rdy       (rd_rdy),
    .ret_valid    (ret_valid),
    .ret_last     (ret_last),
    .ret_data     (ret_data),
    .wr_req       (wr_req),
    .wr_type      (wr_type),
    .wr_addr      (wr_addr),
    .wr_wstrb     (wr_wstrb),
    .wr_data      (wr_data),
    .wr_rdy       (wr_rdy),
`ifdef CACHE_BRIDGE_BUS_ERR_EN
    .bus_err      (bus_err),
    .bus_err_addr (bus_err_addr),
`endif
    .axi          (axi)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive point: just after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sample point: falling edge
  task automatic settle();
    #4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    lrd[0] = 32'hAAAA_AAAA; lrd[1] = 32'hBBBB_BBBB;
    lrd[2] = 32'hCCCC_CCCC; lrd[3] = 32'hDDDD_DDDD;
    lwr[0] = 32'h1111_1110; lwr[1] = 32'h2222_2221;
    lwr[2] = 32'h3333_3332; lwr[3] = 32'h4444_4443;

    reset = 1'b1;
    rd_req = 1'b0; rd_type = '0; rd_addr = '0;
    wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    axi.arready = 1'b0;
    axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0; axi.rvalid = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bid = 4'd1; axi.bresp = '0; axi.bvalid = 1'b0;

    // Reset state
    tick(); tick(); settle();
    check_eq("rst_arvalid", 32'(axi.arvalid), 0);
    check_eq("rst_awvalid", 32'(axi.awvalid), 0);
    check_eq("rst_wvalid", 32'(axi.wvalid), 0);
    check_eq("rst_rready", 32'(axi.rready), 0);
    check_eq("rst_bready", 32'(axi.bready), 0);
    check_eq("rst_ret_valid", 32'(ret_valid), 0);
    check_eq("rst_ret_last", 32'(ret_last), 0);
    check_eq("rst_ret_data", ret_data, 0);
`ifdef CACHE_BRIDGE_BUS_ERR_EN
    check_eq("rst_bus_err", 32'(bus_err), 0);
    check_eq("rst_bus_err_addr", bus_err_addr, 0);
`endif
    tick(); reset = 1'b0; settle();
    check_eq("idle_rd_rdy", 32'(rd_rdy), 1);
    check_eq("idle_wr_rdy", 32'(wr_rdy), 1);

    // Word read
    tick(); rd_req = 1'b1; rd_type = TYPE_WORD; rd_addr = 32'h1000_0004; axi.arready = 1'b1; settle();
    check_eq("wrd_rd_rdy", 32'(rd_rdy), 1);
    tick(); rd_req = 1'b0; settle();
    check_eq("wrd_arvalid", 32'(axi.arvalid), 1);
    check_eq("wrd_araddr", axi.araddr, 32'h1000_0004);
    check_eq("wrd_arlen", 32'(axi.arlen), 0);
    check_eq("wrd_arsize", 32'(axi.arsize), 2);
    check_eq("wrd_arburst", 32'(axi.arburst), 1);
    check_eq("wrd_arid", 32'(axi.arid), 0);
    tick(); axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'hDEAD_BEEF; axi.rlast = 1'b1; settle();
    check_eq("wrd_rready", 32'(axi.rready), 1);
    check_eq("wrd_arvalid_off", 32'(axi.arvalid), 0);
    check_eq("wrd_ret_valid", 32'(ret_valid), 1);
    check_eq("wrd_ret_last", 32'(ret_last), 1);
    check_eq("wrd_ret_data", ret_data, 32'hDEAD_BEEF);
    tick(); axi.rvalid = 1'b0; axi.rlast = 1'b0; settle();
    check_eq("wrd_done_ret_valid", 32'(ret_valid), 0);
    check_eq("wrd_done_rd_rdy", 32'(rd_rdy), 1);

    // Line read with gapped beats
    tick(); rd_req = 1'b1; rd_type = TYPE_LINE; rd_addr = 32'h0000_1238; settle();
    tick(); rd_req = 1'b0; axi.arready = 1'b1; settle();
    check_eq("lrd_arvalid", 32'(axi.arvalid), 1);
    check_eq("lrd_araddr", axi.araddr, 32'h0000_1230);
    check_eq("lrd_arlen", 32'(axi.arlen), 3);
    check_eq("lrd_arsize", 32'(axi.arsize), 2);
    check_eq("lrd_rd_rdy_ar", 32'(rd_rdy), 0);
    tick(); axi.arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi.rvalid = 1'b1; axi.rdata = lrd[i]; axi.rlast = (i == 3); settle();
      check_eq("lrd_ret_valid", 32'(ret_valid), 1);
      check_eq("lrd_ret_last", 32'(ret_last), 32'(i == 3));
      check_eq("lrd_ret_data", ret_data, lrd[i]);
      check_eq("lrd_rd_rdy_beat", 32'(rd_rdy), 0);
      tick(); axi.rvalid = 1'b0; axi.rlast = 1'b0; settle();
      if (i < 3) begin
        check_eq("lrd_gap_ret_valid", 32'(ret_valid), 0);
        check_eq("lrd_gap_rd_rdy", 32'(rd_rdy), 0);
        tick();
      end else begin
        check_eq("lrd_done_rd_rdy", 32'(rd_rdy), 1);
      end
    end

    // Byte write, AW held off three cycles after the W beat
    tick(); wr_req = 1'b1; wr_type = TYPE_BYTE; wr_addr = 32'h0000_0020; wr_wstrb = 4'b0100;
    wr_data = {96'h0, 32'h00AB_0000}; axi.awready = 1'b0; axi.wready = 1'b1; settle();
    check_eq("bw_wr_rdy", 32'(wr_rdy), 1);
    tick(); wr_req = 1'b0; settle();
    check_eq("bw_wvalid", 32'(axi.wvalid), 1);
    check_eq("bw_wlast", 32'(axi.wlast), 1);
    check_eq("bw_wstrb", 32'(axi.wstrb), 32'h4);
    check_eq("bw_wdata", axi.wdata, 32'h00AB_0000);
    check_eq("bw_awvalid", 32'(axi.awvalid), 1);
    check_eq("bw_awaddr", axi.awaddr, 32'h20);
    check_eq("bw_awlen", 32'(axi.awlen), 0);
    check_eq("bw_awsize", 32'(axi.awsize), 0);
    check_eq("bw_awid", 32'(axi.awid), 1);
    check_eq("bw_awburst", 32'(axi.awburst), 1);
    for (int k = 0; k < 3; k++) begin
      tick(); settle();
      check_eq("bw_wait_wvalid", 32'(axi.wvalid), 0);
      check_eq("bw_wait_awvalid", 32'(axi.awvalid), 1);
      check_eq("bw_wait_bready", 32'(axi.bready), 0);
    end
    axi.awready = 1'b1;
    tick(); axi.awready = 1'b0; axi.wready = 1'b0; settle();
    check_eq("bw_b_bready", 32'(axi.bready), 1);
    check_eq("bw_b_awvalid", 32'(axi.awvalid), 0);
    check_eq("bw_b_wr_rdy", 32'(wr_rdy), 0);
    axi.bvalid = 1'b1;
    tick(); axi.bvalid = 1'b0; settle();
    check_eq("bw_done_wr_rdy", 32'(wr_rdy), 1);
    check_eq("bw_done_bready", 32'(axi.bready), 0);

    // Line write with wready toggling
    tick(); wr_req = 1'b1; wr_type = TYPE_LINE; wr_addr = 32'h1234_5678; wr_wstrb = 4'b0001;
    wr_data = {lwr[3], lwr[2], lwr[1], lwr[0]}; axi.awready = 1'b1; axi.wready = 1'b0; settle();
    tick(); wr_req = 1'b0; settle();
    check_eq("lw_awaddr", axi.awaddr, 32'h1234_5670);
    check_eq("lw_awlen", 32'(axi.awlen), 3);
    check_eq("lw_awsize", 32'(axi.awsize), 2);
    for (int k = 0; k < 8; k++) begin
      axi.wready = (k % 2 == 1);
      check_eq("lw_awvalid", 32'(axi.awvalid), 32'(k == 0));
      check_eq("lw_wvalid", 32'(axi.wvalid), 1);
      check_eq("lw_wdata", axi.wdata, lwr[k / 2]);
      check_eq("lw_wstrb", 32'(axi.wstrb), 32'hf);
      check_eq("lw_wlast", 32'(axi.wlast), 32'(k / 2 == 3));
      tick(); axi.awready = 1'b0; settle();
    end
    check_eq("lw_b_bready", 32'(axi.bready), 1);
    check_eq("lw_b_wvalid", 32'(axi.wvalid), 0);
    axi.bvalid = 1'b1;
    tick(); axi.bvalid = 1'b0; axi.wready = 1'b0; settle();
    check_eq("lw_done_wr_rdy", 32'(wr_rdy), 1);

    // Simultaneous read and write: write first
    tick(); rd_req = 1'b1; rd_type = TYPE_WORD; rd_addr = 32'h0000_0040;
    wr_req = 1'b1; wr_type = TYPE_WORD; wr_addr = 32'h0000_0044; wr_wstrb = 4'hf;
    wr_data = {96'h0, 32'h1234_ABCD}; settle();
    check_eq("sim_wr_rdy", 32'(wr_rdy), 1);
    check_eq("sim_rd_rdy", 32'(rd_rdy), 0);
    tick(); wr_req = 1'b0; axi.awready = 1'b1; axi.wready = 1'b1; settle();
    check_eq("sim_aw_rd_rdy", 32'(rd_rdy), 0);
    check_eq("sim_aw_arvalid", 32'(axi.arvalid), 0);
    check_eq("sim_aw_awaddr", axi.awaddr, 32'h0000_0044);
    check_eq("sim_aw_wdata", axi.wdata, 32'h1234_ABCD);
    tick(); axi.awready = 1'b0; axi.wready = 1'b0; settle();
    check_eq("sim_b_bready", 32'(axi.bready), 1);
    check_eq("sim_b_rd_rdy", 32'(rd_rdy), 0);
    axi.bvalid = 1'b1;
    tick(); axi.bvalid = 1'b0; settle();
    check_eq("sim_idle_rd_rdy", 32'(rd_rdy), 1);
    check_eq("sim_idle_arvalid", 32'(axi.arvalid), 0);
    tick(); rd_req = 1'b0; axi.arready = 1'b1; settle();
    check_eq("sim_ar_arvalid", 32'(axi.arvalid), 1);
    check_eq("sim_ar_araddr", axi.araddr, 32'h0000_0040);
    tick(); axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 32'h0000_0055; settle();
    check_eq("sim_r_ret_data", ret_data, 32'h0000_0055);
    check_eq("sim_r_ret_last", 32'(ret_last), 1);
    tick(); axi.rvalid = 1'b0; axi.rlast = 1'b0; settle();

    // Reset in the middle of a read burst
    tick(); rd_req = 1'b1; rd_type = TYPE_LINE; rd_addr = 32'h0000_0100; axi.arready = 1'b1; settle();
    tick(); rd_req = 1'b0; settle();
    tick(); axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'h0000_0001; axi.rlast = 1'b0; settle();
    check_eq("mrst_ret_valid", 32'(ret_valid), 1);
    check_eq("mrst_ret_last", 32'(ret_last), 0);
    tick(); axi.rvalid = 1'b0; reset = 1'b1; settle();
    check_eq("mrst_pre_rready", 32'(axi.rready), 1);
    check_eq("mrst_pre_rd_rdy", 32'(rd_rdy), 0);
    tick(); reset = 1'b0; settle();
    check_eq("mrst_rready", 32'(axi.rready), 0);
    check_eq("mrst_rd_rdy", 32'(rd_rdy), 1);
    check_eq("mrst_arvalid", 32'(axi.arvalid), 0);
    check_eq("mrst_ret_valid_off", 32'(ret_valid), 0);

`ifdef CACHE_BRIDGE_BUS_ERR_EN
    // Error response on a write
    tick(); wr_req = 1'b1; wr_type = TYPE_BYTE; wr_addr = 32'h0000_0ABC; wr_wstrb = 4'b0001;
    wr_data = {96'h0, 32'h0000_00EE}; axi.awready = 1'b1; axi.wready = 1'b1; settle();
    check_eq("err_idle_bus_err", 32'(bus_err), 0);
    tick(); wr_req = 1'b0; settle();
    tick(); axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1; axi.bresp = 2'b10; settle();
    check_eq("err_b_bready", 32'(axi.bready), 1);
    check_eq("err_b_bus_err", 32'(bus_err), 0);
    tick(); axi.bvalid = 1'b0; axi.bresp = 2'b00; settle();
    check_eq("err_pulse", 32'(bus_err), 1);
    check_eq("err_addr", bus_err_addr, 32'h0000_0ABC);
    tick(); settle();
    check_eq("err_pulse_end", 32'(bus_err), 0);
    check_eq("err_addr_hold", bus_err_addr, 32'h0000_0ABC);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
